// File: rtl/krnl_hll_ctrl_seq_if.sv
// Control/handshake bundle for the HLL kernel sequencer.
// master: the sequencer side (drives handshake results and DMA/sketch controls).
// slave : the control-slave / datapath side (drives start, arguments and completions).
// Optional macro KRNL_HLL_SEQ_CYCLE_CNT_EN adds the run_cycles counter output.
interface krnl_hll_ctrl_seq_if #(
  parameter int ADDR_W   = 64,
  parameter int LEN_W    = 32,
  parameter int NUM_REGS = 1024
`ifdef KRNL_HLL_SEQ_CYCLE_CNT_EN
  , parameter int CNT_W  = 48
`endif
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic              ap_start;
  logic              ap_idle;
  logic              ap_ready;
  logic              ap_done;
  logic [ADDR_W-1:0] arg_src;
  logic [LEN_W-1:0]  arg_len;
  logic [ADDR_W-1:0] arg_dst;
  logic              hll_clear;
  logic [IDX_W-1:0]  hll_clr_idx;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_done;
  logic              flush_req;
  logic              flush_done;
  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_done;
`ifdef KRNL_HLL_SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0]  run_cycles;
`endif

  modport master (
    input  ap_start, arg_src, arg_len, arg_dst, rd_done, flush_done, wr_done,
    output ap_idle, ap_ready, ap_done, hll_clear, hll_clr_idx,
           rd_start, rd_addr, rd_len, flush_req, wr_start, wr_addr
`ifdef KRNL_HLL_SEQ_CYCLE_CNT_EN
    , output run_cycles
`endif
  );

  modport slave (
    output ap_start, arg_src, arg_len, arg_dst, rd_done, flush_done, wr_done,
    input  ap_idle, ap_ready, ap_done, hll_clear, hll_clr_idx,
           rd_start, rd_addr, rd_len, flush_req, wr_start, wr_addr
`ifdef KRNL_HLL_SEQ_CYCLE_CNT_EN
    , input run_cycles
`endif
  );
endinterface

// File: rtl/krnl_hll_ctrl_seq.sv
// Kernel-level sequencer for the HLL RTL kernel.
// Accepts ap_start with its arguments, then walks the phases
// sketch clear -> read DMA -> pipeline flush -> write DMA, and reports
// ap_idle/ap_ready/ap_done back to the control slave.
// A zero-length run skips the read DMA entirely.
// Optional macro KRNL_HLL_SEQ_CYCLE_CNT_EN adds a saturating run-cycle counter.
module krnl_hll_ctrl_seq #(
  parameter int ADDR_W   = 64,
  parameter int LEN_W    = 32,
  parameter int NUM_REGS = 1024
`ifdef KRNL_HLL_SEQ_CYCLE_CNT_EN
  , parameter int CNT_W  = 48
`endif
) (
  input  logic                aclk,
  input  logic                areset_n,
  input  logic                aclken,
  krnl_hll_ctrl_seq_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLEAR     = 3'd1;
  localparam logic [2:0] S_LAUNCH_RD = 3'd2;
  localparam logic [2:0] S_READ      = 3'd3;
  localparam logic [2:0] S_FLUSH     = 3'd4;
  localparam logic [2:0] S_LAUNCH_WR = 3'd5;
  localparam logic [2:0] S_WRITE     = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  logic [2:0]        r_state;
  logic [2:0]        w_nextState;
  logic [IDX_W-1:0]  r_clrIdx;
  logic [ADDR_W-1:0] r_srcAddr;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_dstAddr;
  logic              w_accept;
  logic              w_lastClear;

  assign w_accept    = (r_state == S_IDLE) && bus.ap_start && aclken;
  assign w_lastClear = (r_clrIdx == IDX_W'(NUM_REGS - 1));

  // Phase ordering; completion pulses only count in the state that waits for them.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:      if (bus.ap_start) w_nextState = S_CLEAR;
      S_CLEAR:     if (w_lastClear) w_nextState = (r_len != '0) ? S_LAUNCH_RD : S_FLUSH;
      S_LAUNCH_RD: w_nextState = S_READ;
      S_READ:      if (bus.rd_done) w_nextState = S_FLUSH;
      S_FLUSH:     if (bus.flush_done) w_nextState = S_LAUNCH_WR;
      S_LAUNCH_WR: w_nextState = S_WRITE;
      S_WRITE:     if (bus.wr_done) w_nextState = S_DONE;
      S_DONE:      w_nextState = S_IDLE;
      default:     w_nextState = S_IDLE;
    endcase
  end

  // State register; a clock-enable low freezes the whole sequence.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state <= S_IDLE;
    else if (aclken) r_state <= w_nextState;
  end

  // Argument snapshot taken only on accept so later bus changes cannot leak in.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_srcAddr <= '0;
      r_len     <= '0;
      r_dstAddr <= '0;
    end else if (w_accept) begin
      r_srcAddr <= bus.arg_src;
      r_len     <= bus.arg_len;
      r_dstAddr <= bus.arg_dst;
    end
  end

  // Sketch register index walked once per enabled cycle during the clear phase.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_clrIdx <= '0;
    else if (aclken) begin
      if (w_accept) r_clrIdx <= '0;
      else if (r_state == S_CLEAR) r_clrIdx <= w_lastClear ? '0 : r_clrIdx + IDX_W'(1);
    end
  end

`ifdef KRNL_HLL_SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_runCycles;

  // Busy-cycle counter: restarts on accept, saturates, and holds while idle.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_runCycles <= '0;
    else if (aclken) begin
      if (w_accept) r_runCycles <= '0;
      else if ((r_state != S_IDLE) && (r_runCycles != {CNT_W{1'b1}}))
        r_runCycles <= r_runCycles + CNT_W'(1);
    end
  end

  assign bus.run_cycles = r_runCycles;
`endif

  assign bus.ap_idle     = (r_state == S_IDLE);
  assign bus.ap_ready    = w_accept;
  assign bus.ap_done     = (r_state == S_DONE);
  assign bus.hll_clear   = (r_state == S_CLEAR);
  assign bus.hll_clr_idx = r_clrIdx;
  assign bus.rd_start    = (r_state == S_LAUNCH_RD);
  assign bus.rd_addr     = r_srcAddr;
  assign bus.rd_len      = r_len;
  assign bus.flush_req   = (r_state == S_FLUSH);
  assign bus.wr_start    = (r_state == S_LAUNCH_WR);
  assign bus.wr_addr     = r_dstAddr;
endmodule

// File: tb/tb_krnl_hll_ctrl_seq.sv
// Self-checking bench for krnl_hll_ctrl_seq (NUM_REGS reduced to 16).
// Table rows describe a run plus responder delays and the hand-computed
// timing; hand-written sequences cover reset and mid-run abort.
// Honours KRNL_HLL_SEQ_CYCLE_CNT_EN when defined.
module tb_krnl_hll_ctrl_seq;
  localparam int  NumRegs   = 16;
  localparam time ClkPeriod = 10;

  typedef struct {
    logic [63:0] src;
    logic [31:0] len;
    logic [63:0] dst;
    int          rdDelay;
    int          flushDelay;
    int          wrDelay;
    int          strayRd;
    bit          gate;
    bit          holdStart;
    bit          b2b;
    int          expLatency;
    int          expFlushAt;
    int          expRdStarts;
  } vec_t;

  logic aclk;
  logic areset_n;
  logic aclken;
  int   checkCount = 0;
  int   passCount  = 0;
  time  prevDoneTime = 0;
  vec_t vecs[7];

`ifdef KRNL_HLL_SEQ_CYCLE_CNT_EN
  krnl_hll_ctrl_seq_if #(.ADDR_W(64), .LEN_W(32), .NUM_REGS(NumRegs), .CNT_W(48)) bus ();
  krnl_hll_ctrl_seq #(.ADDR_W(64), .LEN_W(32), .NUM_REGS(NumRegs), .CNT_W(48)) dut (
`else
  krnl_hll_ctrl_seq_if #(.ADDR_W(64), .LEN_W(32), .NUM_REGS(NumRegs)) bus ();
  krnl_hll_ctrl_seq #(.ADDR_W(64), .LEN_W(32), .NUM_REGS(NumRegs)) dut (
`endif
    .aclk     (aclk),
    .areset_n (areset_n),
    .aclken   (aclken),
    .bus      (bus.master)
  );

  initial aclk = 1'b0;
  always #(ClkPeriod / 2) aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // One complete run with responders; inputs driven on negedge, outputs sampled 1 time unit later.
  task automatic applyStimulus(input vec_t v);
    int c = 0;
    int readyAt = -1, doneAt = -1, rdAt = -1, flushAt = -1, wrAt = -1;
    int readyCnt = 0, doneCnt = 0, rdCnt = 0, wrCnt = 0, clrCnt = 0, idxErr = 0, offCnt = 0;
    bit inClear = 1'b0;
    while (doneAt < 0 && c < 300) begin
      @(negedge aclk);
      bus.ap_start = v.holdStart ? 1'b1 : (c == 0);
      if (c == 0) begin
        bus.arg_src = v.src;
        bus.arg_len = v.len;
        bus.arg_dst = v.dst;
      end else if (c == 1) begin
        bus.arg_src = 64'hDEAD_BEEF_0000_0000;
        bus.arg_len = 32'h0000_FFFF;
        bus.arg_dst = 64'h0000_0000_0BAD_0000;
      end
      aclken = !(v.gate && inClear && (c % 2 == 0));
      if (!aclken) offCnt++;
      bus.rd_done    = (rdAt >= 0 && c == rdAt + v.rdDelay) || (c == v.strayRd);
      bus.flush_done = (flushAt >= 0 && c == flushAt + v.flushDelay);
      bus.wr_done    = (wrAt >= 0 && c == wrAt + v.wrDelay);
      #1;
      if (bus.ap_ready) begin
        readyCnt++;
        if (readyAt < 0) begin
          readyAt = c;
          if (v.b2b) checkOutput("b2bGap", 64'($time - prevDoneTime), 64'(ClkPeriod));
        end
      end
      if (bus.hll_clear && aclken) begin
        if (bus.hll_clr_idx != clrCnt[3:0]) idxErr++;
        clrCnt++;
      end
      inClear = bus.hll_clear;
      if (bus.rd_start && aclken) begin
        rdCnt++;
        if (rdAt < 0) rdAt = c;
      end
      if (bus.flush_req && flushAt < 0) begin
        flushAt = c;
        if (v.flushDelay == 0) bus.flush_done = 1'b1;
      end
      if (bus.wr_start && aclken) begin
        wrCnt++;
        if (wrAt < 0) wrAt = c;
      end
`ifdef KRNL_HLL_SEQ_CYCLE_CNT_EN
      if (c == 1) checkOutput("cntRestart", bus.run_cycles, 0);
      if (bus.ap_done) checkOutput("cntAtDone", bus.run_cycles, 64'(v.expLatency - 1));
`endif
      if (bus.ap_done) begin
        doneCnt++;
        doneAt = c;
        prevDoneTime = $time;
      end
      c++;
    end
    checkOutput("doneSeen", doneAt >= 0, 1);
    checkOutput("readyCount", readyCnt, 1);
    checkOutput("readyAtStart", readyAt, 0);
    checkOutput("clearCycles", clrCnt, NumRegs);
    checkOutput("clearIdxSeq", idxErr, 0);
    checkOutput("rdStartCount", rdCnt, v.expRdStarts);
    checkOutput("rdAddr", bus.rd_addr, v.src);
    checkOutput("rdLen", bus.rd_len, v.len);
    checkOutput("wrAddr", bus.wr_addr, v.dst);
    checkOutput("wrStartCount", wrCnt, 1);
    checkOutput("doneCount", doneCnt, 1);
    checkOutput("flushEntry", flushAt, v.expFlushAt + offCnt);
    checkOutput("latency", doneAt - readyAt, v.expLatency + offCnt);
    if (!v.holdStart) begin
      @(negedge aclk);
      bus.ap_start   = 1'b0;
      bus.rd_done    = 1'b0;
      bus.flush_done = 1'b0;
      bus.wr_done    = 1'b0;
      aclken         = 1'b1;
      #1;
      checkOutput("idleAfterDone", bus.ap_idle, 1);
      checkOutput("doneOnePulse", bus.ap_done, 0);
    end
  endtask

  initial begin
    int doneCnt = 0;
    int notIdle = 0;
    //            src            len     dst            rd fl wr stray gate hold b2b lat flushAt rdStarts
    vecs[0] = '{64'h1000, 32'd256, 64'h8000, 10, 5, 5, 17, 1'b0, 1'b0, 1'b0, 40, 28, 1};
    vecs[1] = '{64'h3000, 32'd0,   64'h9000,  1, 0, 1, -1, 1'b0, 1'b0, 1'b0, 20, 17, 0};
    vecs[2] = '{64'h0010, 32'd1,   64'h0020,  1, 0, 1, -1, 1'b0, 1'b0, 1'b0, 22, 19, 1};
    vecs[3] = '{64'h4000, 32'd0,   64'hA000,  1, 3, 2, -1, 1'b0, 1'b0, 1'b0, 24, 17, 0};
    vecs[4] = '{64'h1000, 32'd256, 64'h8000, 10, 5, 5, -1, 1'b1, 1'b0, 1'b0, 40, 28, 1};
    vecs[5] = '{64'h1000, 32'd4,   64'h8000,  1, 0, 1, -1, 1'b0, 1'b1, 1'b0, 22, 19, 1};
    vecs[6] = '{64'h2000, 32'd4,   64'h8800,  1, 0, 1, -1, 1'b0, 1'b0, 1'b1, 22, 19, 1};

    areset_n       = 1'b0;
    aclken         = 1'b1;
    bus.ap_start   = 1'b0;
    bus.arg_src    = '0;
    bus.arg_len    = '0;
    bus.arg_dst    = '0;
    bus.rd_done    = 1'b0;
    bus.flush_done = 1'b0;
    bus.wr_done    = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    checkOutput("rstIdle", bus.ap_idle, 1);
    areset_n = 1'b1;
    @(negedge aclk);
    #1;
    checkOutput("postRstIdle", bus.ap_idle, 1);
    checkOutput("postRstRdStart", bus.rd_start, 0);
    checkOutput("postRstWrStart", bus.wr_start, 0);
    checkOutput("postRstClear", bus.hll_clear, 0);
    checkOutput("postRstDone", bus.ap_done, 0);
    checkOutput("postRstReady", bus.ap_ready, 0);
    checkOutput("postRstFlush", bus.flush_req, 0);
    checkOutput("postRstRdAddr", bus.rd_addr, 0);

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    $display("[TB] mid-run reset");
    @(negedge aclk);
    bus.ap_start = 1'b1;
    bus.arg_src  = 64'h1000;
    bus.arg_len  = 32'd256;
    bus.arg_dst  = 64'h8000;
    #1;
    checkOutput("midAccept", bus.ap_ready, 1);
    repeat (20) begin
      @(negedge aclk);
      bus.ap_start = 1'b0;
    end
    #1;
    checkOutput("midInRead", {bus.ap_idle, bus.rd_start, bus.flush_req, bus.hll_clear}, 0);
    checkOutput("midRdAddr", bus.rd_addr, 64'h1000);
    areset_n = 1'b0;
    #1;
    checkOutput("abortIdle", bus.ap_idle, 1);
    checkOutput("abortRdAddr", bus.rd_addr, 0);
    checkOutput("abortRdLen", bus.rd_len, 0);
    checkOutput("abortDone", bus.ap_done, 0);
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      bus.rd_done = (k == 3);
      #1;
      if (bus.ap_done) doneCnt++;
      if (!bus.ap_idle) notIdle++;
    end
    checkOutput("abortNoDone", doneCnt, 0);
    checkOutput("abortStaysIdle", notIdle, 0);
    applyStimulus(vecs[1]);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
